// File: rtl/pcm_frame_packer.sv
// PCM frame packer: buffers multi-channel sample frames and
// serializes them to bytes in WAV data-chunk order.
module pcm_frame_packer #(
  parameter int NUM_CHANNELS    = 2,
  parameter int BITS_PER_SAMPLE = 24,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    frame_valid_i,
  output logic                                    frame_ready_o,
  input  logic [NUM_CHANNELS*BITS_PER_SAMPLE-1:0] frame_data_i,
  input  logic                                    mono_dup_i,
  input  logic                                    big_endian_i,
  output logic                                    byte_valid_o,
  input  logic                                    byte_ready_i,
  output logic [7:0]                              byte_data_o,
  output logic                                    byte_last_o,
  output logic [31:0]                             data_bytes_o,
  output logic                                    busy_o
);

  localparam int BPS = BITS_PER_SAMPLE / 8;
  localparam int W   = NUM_CHANNELS * BITS_PER_SAMPLE;
  localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int CHW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int JW  = (BPS > 1) ? $clog2(BPS) : 1;
  localparam logic [CW-1:0]  FULL    = CW'(FIFO_DEPTH);
  localparam logic [CHW-1:0] LAST_CH = CHW'(NUM_CHANNELS - 1);
  localparam logic [JW-1:0]  LAST_J  = JW'(BPS - 1);
  localparam logic           INV_MSB = (BITS_PER_SAMPLE == 8);

  logic [W-1:0] mem_data [FIFO_DEPTH];
  logic         mem_mono [FIFO_DEPTH];
  logic         mem_be   [FIFO_DEPTH];

  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CHW-1:0] ch_q;
  logic [JW-1:0]  pos_q;

  logic push;
  logic pop;
  logic byte_hs;
  logic pos_last;
  logic at_last;

  logic [NUM_CHANNELS-1:0][BPS-1:0][7:0] head_b;
  logic           head_mono;
  logic           head_be;
  logic [CHW-1:0] ch_sel;
  logic [JW-1:0]  pos_sel;
  logic [7:0]     sel;

  assign frame_ready_o = count < FULL;
  assign busy_o        = count != '0;
  assign byte_valid_o  = busy_o;
  assign pos_last      = pos_q == LAST_J;
  assign at_last       = pos_last && (ch_q == LAST_CH);
  assign byte_last_o   = byte_valid_o && at_last;

  assign push    = frame_valid_i && frame_ready_o;
  assign byte_hs = byte_valid_o && byte_ready_i;
  assign pop     = byte_hs && at_last;

  // Byte index kept as (channel, byte-in-sample) to avoid a divider.
  assign head_b    = mem_data[rd_ptr];
  assign head_mono = mem_mono[rd_ptr];
  assign head_be   = mem_be[rd_ptr];
  assign ch_sel    = head_mono ? '0 : ch_q;
  assign pos_sel   = head_be ? (LAST_J - pos_q) : pos_q;
  assign sel       = head_b[ch_sel][pos_sel];
  assign byte_data_o = {sel[7] ^ INV_MSB, sel[6:0]};

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_data[wr_ptr] <= frame_data_i;
      mem_mono[wr_ptr] <= mono_dup_i;
      mem_be[wr_ptr]   <= big_endian_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      ch_q         <= '0;
      pos_q        <= '0;
      data_bytes_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (byte_hs) begin
        if (pos_last) begin
          pos_q <= '0;
          ch_q  <= at_last ? '0 : ch_q + 1'b1;
        end else begin
          pos_q <= pos_q + 1'b1;
        end
        if (data_bytes_o != '1) data_bytes_o <= data_bytes_o + 1'b1;
      end
    end
  end

endmodule

// File: doc/pcm_frame_packer.md
# pcm_frame_packer

Parametrised PCM frame serializer sitting between the synth core's per-frame sample output and any byte-oriented sink: WAV capture path, UART or SPI bridge, or codec FIFO. It accepts one multi-channel sample frame per valid/ready handshake and buffers up to FIFO_DEPTH frames. Each frame is emitted as a byte stream in WAV data-chunk order, with optional mono duplication and endian flip. It keeps a running data-chunk byte count so a header writer can patch the size field.

## Interface
- NUM_CHANNELS, 2, channel slots per frame (1..8)
- BITS_PER_SAMPLE, 24, sample width; multiple of 8, range 8..32
- FIFO_DEPTH, 4, frame buffer depth; power of 2, ≥2
- clk_i  in  1  single clock; all logic on rising edge
- rst_i  in  1  synchronous, active-high reset
- frame_valid_i  in  1  input frame present
- frame_ready_o  out  1  packer can accept a frame
- frame_data_i  in  NUM_CHANNELS*BITS_PER_SAMPLE  signed samples, ch0 in LSBs
- mono_dup_i  in  1  replicate ch0 into every slot; captured with the frame
- big_endian_i  in  1  MSB byte first within each sample; captured with the frame
- byte_valid_o  out  1  byte_data_o valid
- byte_ready_i  in  1  sink accepts byte
- byte_data_o  out  8  output byte
- byte_last_o  out  1  final byte of current frame
- data_bytes_o  out  32  bytes transferred since reset; saturates at 0xFFFFFFFF
- busy_o  out  1  FIFO non-empty

## Operation
- BPS = BITS_PER_SAMPLE/8; BPF = NUM_CHANNELS*BPS.
- Push: on frame_valid_i && frame_ready_o, store {frame_data_i, mono_dup_i, big_endian_i} at the write pointer.
- frame_ready_o = (count < FIFO_DEPTH), derived from registered count. No pass-through when full: a pop and a push offered in the same full cycle do not push.
- Serializer is first-word-fall-through on the head entry. A byte index register counts 0..BPF-1.
  - Byte k maps to channel k/BPS, byte position j = k%BPS.
  - If mono_dup, the channel is forced to 0.
  - Byte taken = sample[8j+7:8j] when little-endian, sample[8(BPS-1-j)+7:8(BPS-1-j)] when big-endian.
- BITS_PER_SAMPLE==8: the output byte MSB is inverted (signed to WAV unsigned offset binary). No conversion for other widths.
- Byte handshake (byte_valid_o && byte_ready_i): index increments and data_bytes_o increments, saturating. On the last byte, index returns to 0 and the head frame pops.
- byte_valid_o = busy_o = (count != 0). byte_last_o = byte_valid_o && index==BPF-1.
- Simultaneous push and pop: count unchanged, both pointers advance. Pointers wrap modulo FIFO_DEPTH.
- Reset values:
  - frame_ready_o=1; byte_valid_o=0; byte_last_o=0; busy_o=0; data_bytes_o=0.
  - Pointers, count and index = 0. byte_data_o is don't-care while invalid.
- Reset mid-frame: the partial frame and all buffered frames are discarded. The count is cleared and no remaining bytes are emitted.
- byte_data_o and byte_last_o stay stable while byte_valid_o && !byte_ready_i.

## Timing
- Frame accepted at edge N: byte_valid_o high in cycle after N, first byte present. Latency is 1 cycle.
- With byte_ready_i held high: 1 byte/cycle, BPF cycles per frame, no bubbles between consecutive buffered frames.
- frame_ready_o drops the cycle after the push that makes count==FIFO_DEPTH. It rises the cycle after the pop of the last byte.
- data_bytes_o updates the cycle after each byte handshake.
- rst_i asserted at edge N: all outputs hold reset values from cycle after N.

## Test plan
- Stereo/24, LE: ch0=0x123456, ch1=0xABCDEF, byte_ready_i=1 -> bytes 56 34 12 EF CD AB; byte_last_o on 6th only; data_bytes_o=6; busy_o=0 after.
- Same frame with big_endian_i=1 -> 12 34 56 AB CD EF. Next frame with big_endian_i=0 -> LE, proving the flag is captured per frame.
- mono_dup_i=1, ch0=0x000001, ch1=0x7FFFFF -> 01 00 00 01 00 00.
- FIFO_DEPTH=4, byte_ready_i=0, offer 5 frames back-to-back:
  - frame_ready_o low after the 4th push; the 5th is held.
  - Release byte_ready_i -> 24 bytes in order, then the 5th frame.
  - No loss or duplication.
- Random byte_ready_i stalls at 50% over 100 frames -> byte stream matches the reference model; data_bytes_o=600; byte_data_o stable during stalls.
- BITS_PER_SAMPLE=8, mono: samples 0x80, 0x00, 0x7F -> 00 80 FF.
- rst_i after 3 bytes of a 3-frame backlog -> byte_valid_o=0, data_bytes_o=0, frame_ready_o=1 next cycle. A new frame then emits cleanly from byte 0.
